// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: WS2812 serial line in, decoded pixel/frame strobes and forwarded line out
interface ws2812_rx_if #(
  parameter int PIX_W = 8
);
  logic             din;
  logic [23:0]      pixel;
  logic             pixel_valid;
  logic [PIX_W-1:0] pixel_index;
  logic             frame_done;
  logic [PIX_W-1:0] frame_pixels;
  logic             frame_partial;
  logic             err;
  logic             dout;
  modport master (
    output din,
    input  pixel, pixel_valid, pixel_index, frame_done, frame_pixels, frame_partial, err, dout
  );
  modport slave (
    input  din,
    output pixel, pixel_valid, pixel_index, frame_done, frame_pixels, frame_partial, err, dout
  );
endinterface

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ receiver decoding 24-bit GRB words, frame gaps and downstream forwarding
module ws2812_rx #(
  parameter int BIT_THRESH = 14,
  parameter int MIN_HIGH   = 4,
  parameter int MAX_HIGH   = 48,
  parameter int RESET_LOW  = 1200,
  parameter int CNT_W      = 16,
  parameter int PIX_W      = 8
) (
  input logic        clk,
  input logic        rst,
  ws2812_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, ERROR} state_t;
  localparam logic [CNT_W-1:0] BIT_C = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] RST_C = CNT_W'(RESET_LOW);
  state_t           state_q, state_d;
  logic             din_m_q, din_s_q, din_p_q;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [CNT_W-1:0] lcnt_inc;
  logic [4:0]       bitcnt_q, bitcnt_d;
  logic [PIX_W-1:0] pixcnt_q, pixcnt_d;
  logic [22:0]      shreg_q, shreg_d;
  logic [23:0]      pixel_q, pixel_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic [PIX_W-1:0] pixel_index_q, pixel_index_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] frame_pixels_q, frame_pixels_d;
  logic             frame_partial_q, frame_partial_d;
  logic             err_q, err_d;
  logic             dout_q, dout_d;
  logic             rise;
  logic             bit_v;
  assign rise     = din_s_q & ~din_p_q;
  assign bit_v    = hcnt_q >= BIT_C;
  assign lcnt_inc = (&lcnt_q) ? lcnt_q : lcnt_q + 1'b1;
  // Line synchroniser; preset high so a line already high at reset release is not seen as a rise
  always_ff @(posedge clk) begin
    if (rst) begin
      din_m_q <= 1'b1;
      din_s_q <= 1'b1;
      din_p_q <= 1'b1;
    end else begin
      din_m_q <= bus.din;
      din_s_q <= din_m_q;
      din_p_q <= din_s_q;
    end
  end
  // Decoder state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      hcnt_q          <= '0;
      lcnt_q          <= '0;
      bitcnt_q        <= '0;
      pixcnt_q        <= '0;
      shreg_q         <= '0;
      pixel_q         <= '0;
      pixel_valid_q   <= 1'b0;
      pixel_index_q   <= '0;
      frame_done_q    <= 1'b0;
      frame_pixels_q  <= '0;
      frame_partial_q <= 1'b0;
      err_q           <= 1'b0;
      dout_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      hcnt_q          <= hcnt_d;
      lcnt_q          <= lcnt_d;
      bitcnt_q        <= bitcnt_d;
      pixcnt_q        <= pixcnt_d;
      shreg_q         <= shreg_d;
      pixel_q         <= pixel_d;
      pixel_valid_q   <= pixel_valid_d;
      pixel_index_q   <= pixel_index_d;
      frame_done_q    <= frame_done_d;
      frame_pixels_q  <= frame_pixels_d;
      frame_partial_q <= frame_partial_d;
      err_q           <= err_d;
      dout_q          <= dout_d;
    end
  end
  // Pulse-width decode: high width picks the bit, long low ends the frame, overlong high is an error
  always_comb begin
    state_d         = state_q;
    hcnt_d          = hcnt_q;
    lcnt_d          = lcnt_q;
    bitcnt_d        = bitcnt_q;
    pixcnt_d        = pixcnt_q;
    shreg_d         = shreg_q;
    pixel_d         = pixel_q;
    pixel_valid_d   = 1'b0;
    pixel_index_d   = pixel_index_q;
    frame_done_d    = 1'b0;
    frame_pixels_d  = frame_pixels_q;
    frame_partial_d = frame_partial_q;
    err_d           = 1'b0;
    dout_d          = din_s_q & (pixcnt_q != '0) & (state_q != ERROR);
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = CNT_W'(1);
        end
      end
      HIGH: begin
        if (din_s_q) begin
          hcnt_d = hcnt_q + 1'b1;
          if (hcnt_d == MAX_C) begin
            err_d    = 1'b1;
            state_d  = ERROR;
            bitcnt_d = '0;
            pixcnt_d = '0;
            shreg_d  = '0;
            lcnt_d   = '0;
          end
        end else begin
          state_d = LOW;
          lcnt_d  = CNT_W'(1);
          if (hcnt_q >= MIN_C) begin
            shreg_d = {shreg_q[21:0], bit_v};
            if (bitcnt_q == 5'd23) begin
              pixel_d       = {shreg_q, bit_v};
              pixel_valid_d = 1'b1;
              pixel_index_d = pixcnt_q;
              pixcnt_d      = (&pixcnt_q) ? pixcnt_q : pixcnt_q + 1'b1;
              bitcnt_d      = '0;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = CNT_W'(1);
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc >= RST_C) begin
            if (bitcnt_q != '0 || pixcnt_q != '0) begin
              frame_done_d    = 1'b1;
              frame_pixels_d  = pixcnt_q;
              frame_partial_d = bitcnt_q != '0;
            end
            bitcnt_d = '0;
            pixcnt_d = '0;
            shreg_d  = '0;
            lcnt_d   = '0;
            state_d  = IDLE;
          end
        end
      end
      ERROR: begin
        lcnt_d = din_s_q ? '0 : lcnt_inc;
        if (!din_s_q && lcnt_inc >= RST_C) begin
          state_d = IDLE;
          lcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.pixel         = pixel_q;
  assign bus.pixel_valid   = pixel_valid_q;
  assign bus.pixel_index   = pixel_index_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.frame_pixels  = frame_pixels_q;
  assign bus.frame_partial = frame_partial_q;
  assign bus.err           = err_q;
  assign bus.dout          = dout_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized pulse-level stimulus with a queue scoreboard for ws2812_rx
module tb_ws2812_rx;
  localparam int PIX_W      = 8;
  localparam int BIT_THRESH = 14;
  localparam int MIN_HIGH   = 4;
  localparam int MAX_HIGH   = 48;
  typedef struct {
    int          kind;
    logic [23:0] word;
    int          idx;
    logic        part;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int dmode = 0;
  ev_t q[$];
  logic [23:0] mbits = '0;
  int nbits = 0;
  int mpix = 0;
  bit merr = 1'b0;
  logic [2:0] dh = '0;
  always #5 clk = ~clk;
  ws2812_rx_if #(.PIX_W(PIX_W)) bus ();
  ws2812_rx dut (.clk(clk), .rst(rst), .bus(bus.slave));
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endfunction
  function automatic ev_t mk(input int k, input logic [23:0] w, input int i, input logic p);
    ev_t e;
    e.kind = k;
    e.word = w;
    e.idx  = i;
    e.part = p;
    return e;
  endfunction
  task automatic hold(input logic v, input int n);
    bus.din = v;
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic pulse(input int h, input int l);
    bit e;
    e = !merr && h >= MAX_HIGH;
    if (e) begin
      q.push_back(mk(2, '0, 0, 1'b0));
      dmode = 2;
    end else if (mpix > 0 && dmode != 2) dmode = 1;
    hold(1'b1, h);
    if (e) begin
      merr  = 1'b1;
      nbits = 0;
      mpix  = 0;
      mbits = '0;
      dmode = 0;
    end else if (!merr && h >= MIN_HIGH) begin
      mbits = {mbits[22:0], h >= BIT_THRESH};
      nbits++;
      if (nbits == 24) begin
        q.push_back(mk(0, mbits, mpix, 1'b0));
        mpix++;
        nbits = 0;
      end
    end
    hold(1'b0, l);
  endtask
  task automatic gap(input int n);
    if (merr) merr = 1'b0;
    else if (nbits != 0 || mpix != 0) q.push_back(mk(1, '0, mpix, nbits != 0));
    nbits = 0;
    mpix  = 0;
    mbits = '0;
    hold(1'b0, n);
    dmode = 0;
  endtask
  task automatic word(input logic [23:0] w, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = w[23-i];
      if (rnd && $urandom_range(7) == 0) pulse($urandom_range(1, 3), $urandom_range(6, 20));
      if (rnd) pulse(b ? $urandom_range(14, 40) : $urandom_range(4, 13), $urandom_range(6, 40));
      else pulse(b ? 19 : 9, b ? 10 : 20);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_pixel"}, 32'(bus.pixel), 0);
    chk({tag, "_pv"}, 32'(bus.pixel_valid), 0);
    chk({tag, "_idx"}, 32'(bus.pixel_index), 0);
    chk({tag, "_fd"}, 32'(bus.frame_done), 0);
    chk({tag, "_fp"}, 32'(bus.frame_pixels), 0);
    chk({tag, "_fpart"}, 32'(bus.frame_partial), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_dout"}, 32'(bus.dout), 0);
  endtask
  // Monitor: forwarded line against delayed input, strobes against the scoreboard queue
  initial begin : mon
    ev_t e;
    int kind;
    forever begin
      @(negedge clk);
      if (dmode != 2 && !rst) chk("dout", 32'(bus.dout), dmode == 1 ? 32'(dh[2]) : 0);
      dh = {dh[1:0], bus.din};
      if (bus.pixel_valid || bus.frame_done || bus.err) begin
        if (bus.pixel_valid && bus.frame_done) chk("pv_fd_overlap", 1, 0);
        kind = bus.pixel_valid ? 0 : bus.frame_done ? 1 : 2;
        if (q.size() == 0) begin
          chk("unexpected_event", 32'(kind), 32'hffff_ffff);
        end else begin
          e = q.pop_front();
          chk("event_kind", 32'(kind), 32'(e.kind));
          if (kind == 0 && e.kind == 0) begin
            chk("pixel", 32'(bus.pixel), 32'(e.word));
            chk("pixel_index", 32'(bus.pixel_index), 32'(e.idx));
          end
          if (kind == 1 && e.kind == 1) begin
            chk("frame_pixels", 32'(bus.frame_pixels), 32'(e.idx));
            chk("frame_partial", 32'(bus.frame_partial), 32'(e.part));
          end
        end
      end
    end
  end
  // Stimulus
  initial begin
    bus.din = 1'b0;
    @(posedge clk);
    #2;
    hold(1'b0, 4);
    check_idle_outputs("reset");
    rst = 1'b0;
    hold(1'b0, 10);
    word(24'hA53CF0, 24, 1'b0);
    gap(1300);
    chk("pixel_hold", 32'(bus.pixel), 32'hA53CF0);
    word(24'h000001, 24, 1'b0);
    word(24'hFFFFFF, 24, 1'b0);
    word(24'h800000, 24, 1'b0);
    gap(1300);
    word(24'hABC000, 10, 1'b0);
    gap(1300);
    word(24'h123456, 24, 1'b0);
    gap(1300);
    for (int i = 0; i < 24; i++) begin
      logic [23:0] w;
      w = 24'h5A0081;
      if (i % 5 == 2) pulse(2, 12);
      pulse(w[23-i] ? (i == 1 ? 40 : (i % 3 == 0) ? 47 : 14) : 13, 15);
    end
    gap(1300);
    word(24'hC0FFEE, 24, 1'b0);
    word(24'h0F0F0F, 5, 1'b0);
    pulse(60, 100);
    pulse(19, 50);
    gap(1300);
    word(24'h5EED42, 24, 1'b1);
    gap(1300);
    word(24'h111111, 24, 1'b0);
    word(24'h222222, 12, 1'b0);
    dmode = 2;
    hold(1'b1, 5);
    rst = 1'b1;
    hold(1'b1, 4);
    check_idle_outputs("midrst");
    rst   = 1'b0;
    nbits = 0;
    mpix  = 0;
    mbits = '0;
    merr  = 1'b0;
    dmode = 0;
    hold(1'b1, 20);
    hold(1'b0, 30);
    word(24'h333333, 24, 1'b0);
    gap(1300);
    for (int f = 0; f < 5; f++) begin
      int np;
      np = $urandom_range(1, 4);
      for (int p = 0; p < np; p++) word(24'($urandom), 24, 1'b1);
      if ($urandom_range(2) == 0) word(24'($urandom), $urandom_range(1, 23), 1'b1);
      gap(1300);
    end
    hold(1'b0, 20);
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
Single-wire WS2812 NRZ receiver and decoder: the other end of the LED strip driver.
- Measures high-pulse width on `din` and decodes 24-bit GRB words, MSB first.
- Detects the low-time reset/latch gap, which ends a frame.
- Forwards the stream downstream after consuming the first pixel, as a real WS2812 cell does.
- Used as an in-fabric loopback checker for the strip driver and as a strip emulator on the FPGA.

Parameters:
BIT_THRESH, 14, high width in clk cycles at or above which a bit decodes as 1 (0-bit is ~9, 1-bit is ~19).
MIN_HIGH, 4, high pulses shorter than this are glitches and are ignored.
MAX_HIGH, 48, high count reaching this value is a protocol error.
RESET_LOW, 1200, low cycles that end a frame (50 us at 24 MHz).
CNT_W, 16, width of the high and low counters; must hold RESET_LOW.
PIX_W, 8, width of the pixel counters.

Ports:
clk  in  1  system clock.
rst  in  1  reset, synchronous, active-high.
din  in  1  asynchronous serial line from the driver/strip.
pixel  out  24  last decoded word, {G,R,B}, first received bit in [23].
pixel_valid  out  1  one-cycle strobe; `pixel` and `pixel_index` are valid.
pixel_index  out  PIX_W  index of the strobed pixel within the current frame, 0-based.
frame_done  out  1  one-cycle strobe when the reset gap is detected.
frame_pixels  out  PIX_W  complete pixels in the finished frame; valid with `frame_done`.
frame_partial  out  1  with `frame_done`: the frame ended with 1–23 leftover bits.
err  out  1  one-cycle strobe when a high pulse reaches MAX_HIGH.
dout  out  1  forwarded stream for a downstream cell.

Behaviour:
- Input sync: `din` → ff1 → `din_s`; a third flop gives `din_q`. Rise = `din_s & ~din_q`. All decode uses `din_s`.
- Reset state: every output 0, FSM in IDLE, all counters cleared, shift register cleared. Reset mid-frame discards partial data with no strobes.

States:
- IDLE: wait for a rise, then go to HIGH with hcnt=1. A line already high at reset release is ignored until the next rise.
- HIGH: while `din_s`=1, hcnt++. If hcnt reaches MAX_HIGH, strobe `err`, discard bits and pixel count, go to ERROR.
- HIGH, on `din_s`=0:
  - If hcnt < MIN_HIGH: glitch, no bit, go to LOW with lcnt=1 (prior bits kept).
  - Otherwise: bit = (hcnt >= BIT_THRESH); shreg <= {shreg[22:0], bit}; bitcnt++; go to LOW with lcnt=1.
- LOW: on a rise, go to HIGH with hcnt=1. Otherwise lcnt++ (saturating). When lcnt reaches RESET_LOW:
  - If any bit or pixel was received since the last frame end, strobe `frame_done` with `frame_pixels` = pixcnt and `frame_partial` = (bitcnt != 0).
  - Clear bitcnt, pixcnt and shreg, then go to IDLE.
- ERROR: `dout` forced 0 and rises ignored. Leave to IDLE only after `din_s` has been low for RESET_LOW cycles. No `frame_done` is produced.

Pixel completion:
- On the 24th bit, `pixel` <= {shreg[22:0], bit}, `pixel_valid`=1 and `pixel_index`=pixcnt, all in the same registered cycle.
- Then pixcnt++ (saturating at all-ones) and bitcnt <= 0.
- Latency: `pixel_valid` is high in the cycle after the 3rd rising clk edge following the final falling edge of `din` (2 sync + 1 decode).

Forwarding:
- `dout` = registered `din_s` when pixcnt >= 1 and state != ERROR; else 0.
- Pixel 0 is consumed. Forwarding starts the cycle after pixel 0's strobe and stops when `frame_done` clears pixcnt.

Boundary cases:
- `frame_done` and `pixel_valid` never coincide.
- The 24th bit's strobe and a new rise in the same cycle: the bit is still committed; the new pulse starts at hcnt=1.
- `pixel` holds its value between strobes.
- The first pulse after driver reset (~38–40 cycles high) decodes as 1 because it is below MAX_HIGH.

Test Plan:
1. One frame of pixel 0x A5_3C_F0 (1: 19 high/10 low, 0: 9 high/20 low), then 1300 low → `pixel_valid` once, `pixel`=0xA53CF0, `pixel_index`=0; then `frame_done`, `frame_pixels`=1, `frame_partial`=0; `dout` stays 0 throughout.
2. Three pixels 0x000001, 0xFFFFFF, 0x800000 back-to-back → three strobes with indices 0,1,2 and matching words; `dout` mirrors `din` (3-cycle delay) from the first bit of pixel 1 onward; `frame_pixels`=3.
3. 10 bits, then 1300 low → no `pixel_valid`; `frame_done` with `frame_pixels`=0 and `frame_partial`=1. The next frame decodes cleanly from bit 0.
4. Pulses 2 cycles high mid-word → ignored; word decodes as if the glitch were absent. A 13-cycle high decodes as 0; a 14-cycle high decodes as 1.
5. `din` held high 60 cycles → `err` strobe at hcnt=48. Rises ignored until 1200 low, then the next frame decodes normally with no `frame_done` for the aborted one.
6. `rst` asserted after 12 bits of pixel 1, with `din` high at release → no strobes. The current high pulse is ignored; the next rise starts a clean frame at `pixel_index` 0.
